vec_cmd_sequencer: RTL and testbench

Buffers vector-unit commands from a host and issues them one at a time, in order, to the vector register file and ALU/dot-product datapath (`top`). It owns the datapath's `v_i`/`ready_o`/`done_o` and `v_o`/`yumi_i` handshakes, captures read results, and returns them to the host. Undecodable opcodes are filtered before issue. The block sits between the host command port and `top`.

---
 rtl/vec_cmd_sequencer_if.sv | 88 ++++++++
 rtl/vec_cmd_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_vec_cmd_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_cmd_sequencer_if.sv
// rtl/vec_cmd_sequencer_if.sv - host command, datapath and read-result bundle for vec_cmd_sequencer
//
// Purpose: groups every handshake/bus signal of vec_cmd_sequencer so the
// sequencer and its environment connect through one port.
//
// Signal summary (directions as seen by the sequencer, modport slave):
//   cmd_*      host command port (valid/ready, opcode, addresses, scalar, data)
//   vu_*       issued command fields and handshakes to/from the datapath
//   res_*      read-result port (valid/yumi, data)
//   err_o      one-cycle pulse per dropped illegal opcode
//   busy_o     command queue non-empty or sequencer not idle
//   perf_*     activity counters, present only with VEC_SEQ_PERF_EN defined
//
// The master modport is the environment view (host + datapath + result sink).

interface vec_cmd_sequencer_if #(
  parameter int els_p  = 10,
  parameter int vlen_p = 4,
  parameter int vdw_p  = 4
) ();
  localparam int aw = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int dw = vlen_p * vdw_p;

  logic              cmd_v_i;
  logic              cmd_ready_o;
  logic [3:0]        cmd_op_i;
  logic [aw-1:0]     cmd_addrA_i;
  logic [aw-1:0]     cmd_addrB_i;
  logic [aw-1:0]     cmd_addrD_i;
  logic [vdw_p-1:0]  cmd_scalar_i;
  logic [dw-1:0]     cmd_data_i;

  logic [3:0]        vu_op_o;
  logic [aw-1:0]     vu_addrA_o;
  logic [aw-1:0]     vu_addrB_o;
  logic [aw-1:0]     vu_addrD_o;
  logic [vdw_p-1:0]  vu_scalar_o;
  logic [dw-1:0]     vu_w_data_o;
  logic              vu_v_o;
  logic              vu_ready_i;
  logic              vu_done_i;
  logic [dw-1:0]     vu_r_data_i;
  logic              vu_rv_i;
  logic              vu_yumi_o;

  logic              res_v_o;
  logic [dw-1:0]     res_data_o;
  logic              res_yumi_i;

  logic              err_o;
  logic              busy_o;

`ifdef VEC_SEQ_PERF_EN
  logic [31:0]       perf_busy_cycles_o;
  logic [15:0]       perf_cmds_done_o;
  logic [7:0]        perf_err_cnt_o;
`endif

  modport slave (
`ifdef VEC_SEQ_PERF_EN
    output perf_busy_cycles_o, perf_cmds_done_o, perf_err_cnt_o,
`endif
    input  cmd_v_i, cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrD_i,
    input  cmd_scalar_i, cmd_data_i,
    output cmd_ready_o,
    output vu_op_o, vu_addrA_o, vu_addrB_o, vu_addrD_o, vu_scalar_o, vu_w_data_o,
    output vu_v_o, vu_yumi_o,
    input  vu_ready_i, vu_done_i, vu_r_data_i, vu_rv_i,
    output res_v_o, res_data_o,
    input  res_yumi_i,
    output err_o, busy_o
  );

  modport master (
`ifdef VEC_SEQ_PERF_EN
    input  perf_busy_cycles_o, perf_cmds_done_o, perf_err_cnt_o,
`endif
    output cmd_v_i, cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrD_i,
    output cmd_scalar_i, cmd_data_i,
    input  cmd_ready_o,
    input  vu_op_o, vu_addrA_o, vu_addrB_o, vu_addrD_o, vu_scalar_o, vu_w_data_o,
    input  vu_v_o, vu_yumi_o,
    output vu_ready_i, vu_done_i, vu_r_data_i, vu_rv_i,
    input  res_v_o, res_data_o,
    output res_yumi_i,
    input  err_o, busy_o
  );
endinterface

// File: rtl/vec_cmd_sequencer.sv
// rtl/vec_cmd_sequencer.sv - in-order vector command sequencer with illegal-opcode filter
//
// Purpose: queues host vector commands in a small FIFO, drops undecodable
// opcodes (err_o pulse), issues legal ones one at a time to the datapath,
// captures read data and presents it on the result port until accepted.
//
// Ports:
//   clk_i    single clock
//   reset_i  synchronous active-high reset (shared with the datapath)
//   bus      vec_cmd_sequencer_if.slave: cmd_*, vu_*, res_*, err_o, busy_o
//            (plus perf_* counters when VEC_SEQ_PERF_EN is defined)
//
// Optional feature macro: VEC_SEQ_PERF_EN (busy-cycle, completed-command and
// dropped-opcode counters).

module vec_cmd_sequencer #(
  parameter int els_p      = 10,
  parameter int vlen_p     = 4,
  parameter int vdw_p      = 4,
  parameter int fifo_els_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  vec_cmd_sequencer_if.slave bus
);
  localparam int aw = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int dw = vlen_p * vdw_p;
  localparam int pw = $clog2(fifo_els_p);
  localparam int cw = pw + 1;

  localparam logic [3:0] OP_READ = 4'b1000;

  typedef struct packed {
    logic [3:0]       op;
    logic [aw-1:0]    addr_a;
    logic [aw-1:0]    addr_b;
    logic [aw-1:0]    addr_d;
    logic [vdw_p-1:0] scalar;
    logic [dw-1:0]    data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_n;
  cmd_t          mem [fifo_els_p];
  cmd_t          cmd_in, head, issue_q;
  logic [pw-1:0] wr_ptr_q, rd_ptr_q;
  logic [cw-1:0] count_q;
  logic [dw-1:0] res_q;
  logic          captured_q;

  logic full, empty, push, pop, load_issue, head_legal, issue_is_read;
  logic vu_v, vu_yumi, res_v, err, busy;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010,
      4'b0100, 4'b0101, 4'b0110,
      4'b1000, 4'b1001, 4'b1111: op_legal = 1'b1;
      default:                   op_legal = 1'b0;
    endcase
  endfunction

  assign cmd_in = '{op:     bus.cmd_op_i,
                    addr_a: bus.cmd_addrA_i,
                    addr_b: bus.cmd_addrB_i,
                    addr_d: bus.cmd_addrD_i,
                    scalar: bus.cmd_scalar_i,
                    data:   bus.cmd_data_i};

  // Count register separates full from empty since the pointers alias on wrap.
  assign full          = (count_q == cw'(fifo_els_p));
  assign empty         = (count_q == '0);
  assign push          = bus.cmd_v_i & ~full;
  assign head          = mem[rd_ptr_q];
  assign head_legal    = op_legal(head.op);
  assign issue_is_read = (issue_q.op == OP_READ);
  assign busy          = ~empty | (state_q != IDLE);

  always_comb begin
    state_n    = state_q;
    pop        = 1'b0;
    load_issue = 1'b0;
    err        = 1'b0;
    vu_v       = 1'b0;
    vu_yumi    = 1'b0;
    res_v      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_legal) begin
            load_issue = 1'b1;
            state_n    = ISSUE;
          end else begin
            err = 1'b1;
          end
        end
      end
      ISSUE: begin
        vu_v = 1'b1;
        if (bus.vu_ready_i) state_n = WAIT;
      end
      WAIT: begin
        vu_yumi = issue_is_read;
        if (bus.vu_done_i) state_n = issue_is_read ? RESP : IDLE;
      end
      RESP: begin
        res_v = 1'b1;
        if (bus.res_yumi_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Queue storage carries no reset: the count register alone defines validity.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= cmd_in;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      issue_q    <= '0;
      res_q      <= '0;
      captured_q <= 1'b0;
    end else begin
      state_q <= state_n;
      if (push) wr_ptr_q <= wr_ptr_q + pw'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + pw'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + cw'(1);
        2'b01:   count_q <= count_q - cw'(1);
        default: count_q <= count_q;
      endcase
      if (load_issue) begin
        issue_q    <= head;
        captured_q <= 1'b0;
      end
      // Data is taken on the rv/yumi beat; if done shows up with no beat
      // seen, the data bus is sampled alongside done instead.
      if (state_q == WAIT && issue_is_read) begin
        if (bus.vu_rv_i) begin
          res_q      <= bus.vu_r_data_i;
          captured_q <= 1'b1;
        end else if (bus.vu_done_i && !captured_q) begin
          res_q <= bus.vu_r_data_i;
        end
      end
    end
  end

  assign bus.cmd_ready_o = ~full;
  assign bus.vu_op_o     = issue_q.op;
  assign bus.vu_addrA_o  = issue_q.addr_a;
  assign bus.vu_addrB_o  = issue_q.addr_b;
  assign bus.vu_addrD_o  = issue_q.addr_d;
  assign bus.vu_scalar_o = issue_q.scalar;
  assign bus.vu_w_data_o = issue_q.data;
  assign bus.vu_v_o      = vu_v;
  assign bus.vu_yumi_o   = vu_yumi;
  assign bus.res_v_o     = res_v;
  assign bus.res_data_o  = res_q;
  assign bus.err_o       = err;
  assign bus.busy_o      = busy;

`ifdef VEC_SEQ_PERF_EN
  logic [31:0] perf_busy_q;
  logic [15:0] perf_done_q;
  logic [7:0]  perf_err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_busy_q <= '0;
      perf_done_q <= '0;
      perf_err_q  <= '0;
    end else begin
      if (busy && perf_busy_q != '1) perf_busy_q <= perf_busy_q + 32'd1;
      if (state_q == WAIT && bus.vu_done_i) perf_done_q <= perf_done_q + 16'd1;
      if (err && perf_err_q != '1) perf_err_q <= perf_err_q + 8'd1;
    end
  end

  assign bus.perf_busy_cycles_o = perf_busy_q;
  assign bus.perf_cmds_done_o   = perf_done_q;
  assign bus.perf_err_cnt_o     = perf_err_q;
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_vec_cmd_sequencer.sv
// tb/tb_vec_cmd_sequencer.sv - self-checking bench for vec_cmd_sequencer with a behavioural datapath
module tb_vec_cmd_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vec_cmd_sequencer_if #(.els_p(10), .vlen_p(4), .vdw_p(4)) bus ();

  vec_cmd_sequencer #(.els_p(10), .vlen_p(4), .vdw_p(4), .fifo_els_p(4)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_issue  = 0;
  int n_err    = 0;
  logic [3:0] issued_d [$];

  // Behavioural datapath: register file + nibble-wise ALU.
  logic [15:0] rf [10];
  logic        m_busy = 1'b0, m_read = 1'b0, m_got = 1'b0;
  int          m_lat = 0;
  logic [15:0] m_rdata = '0;
  logic        ready_gate = 1'b1;
  logic        skip_rv = 1'b0;
  int          lat_cfg = 2;

  assign bus.vu_ready_i  = ready_gate && !m_busy;
  assign bus.vu_rv_i     = m_busy && (m_lat == 0) && m_read && !m_got && !skip_rv;
  assign bus.vu_done_i   = m_busy && (m_lat == 0) && (!m_read || m_got || skip_rv);
  assign bus.vu_r_data_i = m_rdata;

  function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] va,
                                      input logic [15:0] vb, input logic [3:0] s,
                                      input logic [15:0] w);
    logic [15:0] r;
    logic [3:0]  ea, eb, e;
    logic [7:0]  acc;
    r = '0;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      ea = va[i*4 +: 4];
      eb = vb[i*4 +: 4];
      case (op)
        4'h0: e = ea + eb;
        4'h1: e = ea - eb;
        4'h2: e = ea * eb;
        4'h4: e = ea + s;
        4'h5: e = ea - s;
        4'h6: e = ea * s;
        default: e = 4'h0;
      endcase
      r[i*4 +: 4] = e;
      acc = acc + 8'(ea * eb);
    end
    if (op == 4'h9) r = w;
    if (op == 4'hF) r = {4{acc[3:0]}};
    return r;
  endfunction

  initial for (int i = 0; i < 10; i++) rf[i] = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_got  <= 1'b0;
    end else if (bus.vu_v_o && bus.vu_ready_i) begin
      m_busy  <= 1'b1;
      m_lat   <= lat_cfg;
      m_got   <= 1'b0;
      m_read  <= (bus.vu_op_o == 4'h8);
      m_rdata <= rf[bus.vu_addrA_o];
      if (bus.vu_op_o != 4'h8)
        rf[bus.vu_addrD_o] <= alu(bus.vu_op_o, rf[bus.vu_addrA_o], rf[bus.vu_addrB_o],
                                  bus.vu_scalar_o, bus.vu_w_data_o);
    end else if (m_busy) begin
      if (m_lat > 0) m_lat <= m_lat - 1;
      else if (bus.vu_rv_i && bus.vu_yumi_o) m_got <= 1'b1;
      else if (bus.vu_done_i) m_busy <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (bus.vu_v_o && bus.vu_ready_i) begin
        n_issue = n_issue + 1;
        issued_d.push_back(bus.vu_addrD_o);
      end
      if (bus.err_o) n_err = n_err + 1;
    end
  end

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  d;
    logic [3:0]  s;
    logic [15:0] w;
    logic        legal;
    logic [15:0] exp_res;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic enq(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] d, input logic [3:0] s, input logic [15:0] w);
    int k;
    k = 0;
    while (!bus.cmd_ready_o && k < 50) begin @(negedge clk); k++; end
    if (k == 50) chk("enq_ready_timeout", 32'(bus.cmd_ready_o), 32'd1);
    bus.cmd_op_i     = op;
    bus.cmd_addrA_i  = a;
    bus.cmd_addrB_i  = b;
    bus.cmd_addrD_i  = d;
    bus.cmd_scalar_i = s;
    bus.cmd_data_i   = w;
    bus.cmd_v_i      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_v_i = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy_o && k < 60) begin @(negedge clk); k++; end
    chk("idle_after", 32'(bus.busy_o), 32'd0);
  endtask

  task automatic run_cmd(input vec_t v);
    int k, iss0, err0;
    iss0 = n_issue;
    err0 = n_err;
    enq(v.op, v.a, v.b, v.d, v.s, v.w);
    if (!v.legal) begin
      @(negedge clk);
      chk("illegal_err_pulse", 32'(n_err), 32'(err0 + 1));
      chk("illegal_not_issued", 32'(n_issue), 32'(iss0));
      chk("illegal_idle", 32'(bus.busy_o), 32'd0);
    end else begin
      k = 0;
      while (!bus.vu_v_o && k < 20) begin @(negedge clk); k++; end
      chk("issue_seen", 32'(bus.vu_v_o), 32'd1);
      chk("issue_op", 32'(bus.vu_op_o), 32'(v.op));
      chk("issue_addrA", 32'(bus.vu_addrA_o), 32'(v.a));
      chk("issue_addrB", 32'(bus.vu_addrB_o), 32'(v.b));
      chk("issue_addrD", 32'(bus.vu_addrD_o), 32'(v.d));
      chk("issue_scalar", 32'(bus.vu_scalar_o), 32'(v.s));
      chk("issue_wdata", 32'(bus.vu_w_data_o), 32'(v.w));
      if (v.op == 4'h8) begin
        k = 0;
        while (!bus.res_v_o && k < 40) begin @(negedge clk); k++; end
        chk("res_v", 32'(bus.res_v_o), 32'd1);
        chk("res_data", 32'(bus.res_data_o), 32'(v.exp_res));
        repeat (2) @(negedge clk);
        chk("res_v_held", 32'(bus.res_v_o), 32'd1);
        bus.res_yumi_i = 1'b1;
        @(negedge clk);
        bus.res_yumi_i = 1'b0;
        chk("res_v_drop", 32'(bus.res_v_o), 32'd0);
      end
      wait_idle();
      chk("one_issue", 32'(n_issue), 32'(iss0 + 1));
    end
  endtask

  initial begin
    int k, iss0, err0;
    bus.cmd_v_i = 1'b0;
    bus.cmd_op_i = '0;
    bus.cmd_addrA_i = '0;
    bus.cmd_addrB_i = '0;
    bus.cmd_addrD_i = '0;
    bus.cmd_scalar_i = '0;
    bus.cmd_data_i = '0;
    bus.res_yumi_i = 1'b0;

    //          op     a     b     d     s     w        legal exp
    vecs[0]  = '{4'h9, 4'd0, 4'd0, 4'd1, 4'd0, 16'h0101, 1'b1, 16'h0000};
    vecs[1]  = '{4'h9, 4'd0, 4'd0, 4'd2, 4'd0, 16'h1144, 1'b1, 16'h0000};
    vecs[2]  = '{4'h0, 4'd1, 4'd2, 4'd0, 4'd0, 16'h0000, 1'b1, 16'h0000};
    vecs[3]  = '{4'h8, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b1, 16'h1245};
    vecs[4]  = '{4'h1, 4'd2, 4'd1, 4'd3, 4'd0, 16'h0000, 1'b1, 16'h0000};
    vecs[5]  = '{4'h2, 4'd1, 4'd3, 4'd5, 4'd0, 16'h0000, 1'b1, 16'h0000};
    vecs[6]  = '{4'h8, 4'd5, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b1, 16'h0003};
    vecs[7]  = '{4'h8, 4'd3, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b1, 16'h1043};
    vecs[8]  = '{4'h4, 4'd2, 4'd0, 4'd6, 4'd2, 16'h0000, 1'b1, 16'h0000};
    vecs[9]  = '{4'h8, 4'd6, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b1, 16'h3366};
    vecs[10] = '{4'h6, 4'd1, 4'd0, 4'd7, 4'd3, 16'h0000, 1'b1, 16'h0000};
    vecs[11] = '{4'h8, 4'd7, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b1, 16'h0303};
    vecs[12] = '{4'h5, 4'd2, 4'd0, 4'd6, 4'd5, 16'h0000, 1'b1, 16'h0000};
    vecs[13] = '{4'h8, 4'd6, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b1, 16'hCCFF};
    vecs[14] = '{4'hA, 4'd1, 4'd2, 4'd3, 4'd0, 16'h0000, 1'b0, 16'h0000};
    vecs[15] = '{4'h3, 4'd1, 4'd2, 4'd3, 4'd0, 16'h0000, 1'b0, 16'h0000};
    vecs[16] = '{4'hF, 4'd0, 4'd1, 4'd8, 4'd0, 16'h0000, 1'b1, 16'h0000};
    vecs[17] = '{4'h7, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 16'h0000};

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("rst_vu_v", 32'(bus.vu_v_o), 32'd0);
    chk("rst_vu_yumi", 32'(bus.vu_yumi_o), 32'd0);
    chk("rst_res_v", 32'(bus.res_v_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_res_data", 32'(bus.res_data_o), 32'd0);
    chk("rst_vu_wdata", 32'(bus.vu_w_data_o), 32'd0);

    // Enqueue into an empty idle block: issue one cycle after the pop cycle.
    enq(4'h9, 4'd0, 4'd0, 4'd9, 4'd0, 16'h0000);
    chk("lat_not_yet", 32'(bus.vu_v_o), 32'd0);
    chk("lat_busy", 32'(bus.busy_o), 32'd1);
    @(negedge clk);
    chk("lat_issue", 32'(bus.vu_v_o), 32'd1);
    wait_idle();

    for (int i = 0; i < 18; i++) run_cmd(vecs[i]);

    // Read whose done arrives with data and no separate rv beat.
    skip_rv = 1'b1;
    run_cmd('{4'h8, 4'd3, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b1, 16'h1043});
    skip_rv = 1'b0;

    // Fill the queue behind a stalled issue.
    ready_gate = 1'b0;
    iss0 = n_issue;
    issued_d.delete();
    for (int i = 0; i < 5; i++) enq(4'h9, 4'd0, 4'd0, 4'(i + 1), 4'd0, 16'h1000 + 16'(i));
    chk("full_ready_low", 32'(bus.cmd_ready_o), 32'd0);
    chk("stall_vu_v", 32'(bus.vu_v_o), 32'd1);
    chk("stall_addrD", 32'(bus.vu_addrD_o), 32'd1);
    repeat (3) @(negedge clk);
    chk("full_still_low", 32'(bus.cmd_ready_o), 32'd0);
    chk("stall_held_addrD", 32'(bus.vu_addrD_o), 32'd1);
    chk("stall_no_issue", 32'(n_issue), 32'(iss0));
    ready_gate = 1'b1;
    k = 0;
    while (!bus.cmd_ready_o && k < 40) begin @(negedge clk); k++; end
    chk("ready_after_pop", 32'(bus.cmd_ready_o), 32'd1);
    chk("issues_at_reopen", 32'(n_issue), 32'(iss0 + 1));
    wait_idle();
    chk("fill_issue_count", 32'(n_issue), 32'(iss0 + 5));
    for (int i = 0; i < 5; i++)
      chk("fill_order", 32'((i < issued_d.size()) ? issued_d[i] : 4'hF), 32'(i + 1));
    run_cmd('{4'h8, 4'd4, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b1, 16'h1003});

    // Illegal opcode sandwiched between two writes.
    iss0 = n_issue;
    err0 = n_err;
    enq(4'h9, 4'd0, 4'd0, 4'd8, 4'd0, 16'h00AA);
    enq(4'hA, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000);
    enq(4'h9, 4'd0, 4'd0, 4'd9, 4'd0, 16'h0055);
    wait_idle();
    chk("sandwich_err_count", 32'(n_err), 32'(err0 + 1));
    chk("sandwich_issues", 32'(n_issue), 32'(iss0 + 2));
    run_cmd('{4'h8, 4'd8, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b1, 16'h00AA});
    run_cmd('{4'h8, 4'd9, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b1, 16'h0055});

    // Reset during WAIT of a read with two commands queued behind it.
    lat_cfg = 8;
    enq(4'h8, 4'd9, 4'd0, 4'd0, 4'd0, 16'h0000);
    enq(4'h9, 4'd0, 4'd0, 4'd1, 4'd0, 16'h7777);
    enq(4'h9, 4'd0, 4'd0, 4'd2, 4'd0, 16'h6666);
    k = 0;
    while (!bus.vu_yumi_o && k < 20) begin @(negedge clk); k++; end
    chk("mid_wait_yumi", 32'(bus.vu_yumi_o), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("mid_rst_vu_v", 32'(bus.vu_v_o), 32'd0);
    chk("mid_rst_vu_yumi", 32'(bus.vu_yumi_o), 32'd0);
    chk("mid_rst_res_v", 32'(bus.res_v_o), 32'd0);
    chk("mid_rst_err", 32'(bus.err_o), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    chk("mid_rst_res_data", 32'(bus.res_data_o), 32'd0);
    chk("mid_rst_vu_op", 32'(bus.vu_op_o), 32'd0);
    reset = 1'b0;
    lat_cfg = 2;
    iss0 = n_issue;
    repeat (10) @(negedge clk);
    chk("post_rst_no_issue", 32'(n_issue), 32'(iss0));
    chk("post_rst_busy", 32'(bus.busy_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
